// File: rtl/regbank_arbiter_pkg.sv
// Shared defaults and FSM encoding for the register-bank arbiter.
package regbank_arbiter_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_DEPTH      = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_NR_REQ     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regbank_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
    parameter int unsigned NR_REQ = 4
) (
    input  logic [NR_REQ-1:0]         req,
    input  logic [$clog2(NR_REQ)-1:0] ptr,
    input  logic                      enable,
    output logic [NR_REQ-1:0]         gnt,
    output logic [$clog2(NR_REQ)-1:0] gnt_idx
);

    localparam int unsigned PTR_W = $clog2(NR_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Walk the requesters starting at ptr, wrapping explicitly at NR_REQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NR_REQ)) begin
                sum = sum - (PTR_W+1)'(NR_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Register bank shared by NR_REQ requesters, with round-robin access and a swept clear.
module regbank_arbiter
    import regbank_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NR_REQ     = DEF_NR_REQ
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [NR_REQ-1:0]            req_i,
    input  logic [NR_REQ-1:0]            we_i,
    input  logic [NR_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_REQ*WIDTH-1:0]      wdata_i,
    input  logic                         clear_i,
    output logic [NR_REQ-1:0]            gnt_o,
    output logic [NR_REQ-1:0]            rvalid_o,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         busy_o
);

    localparam int unsigned PTR_W = $clog2(NR_REQ);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    state_t                  state, next_state;
    logic [CNT_W-1:0]        clr_cnt, clr_cnt_d;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        gnt_idx;
    logic                    arb_en;
    logic                    gnt_fire;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [WIDTH-1:0]        sel_wdata;
    logic [WIDTH-1:0]        bank [DEPTH];

    // Arbitrate only when idle and no clear is being requested this cycle.
    assign arb_en   = (state == IDLE) && !clear_i;
    assign gnt_fire = |gnt_o;

    rr_arbiter #(
        .NR_REQ (NR_REQ)
    ) u_rr (
        .req     (req_i),
        .ptr     (rr_ptr),
        .enable  (arb_en),
        .gnt     (gnt_o),
        .gnt_idx (gnt_idx)
    );

    // Mux the granted requester's command onto the bank port.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            if (gnt_o[k]) begin
                sel_we    = we_i[k];
                sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // FSM state register and clear counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy_o  <= 1'b0;
        end else begin
            state   <= next_state;
            clr_cnt <= clr_cnt_d;
            busy_o  <= (next_state == CLEAR);
        end
    end

    // Next-state logic: a clear sweeps one entry per cycle, then returns to IDLE.
    always_comb begin
        next_state = state;
        clr_cnt_d  = clr_cnt;
        case (state)
            IDLE: begin
                if (clear_i) begin
                    next_state = CLEAR;
                    clr_cnt_d  = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt == CNT_W'(DEPTH - 1)) begin
                    next_state = IDLE;
                    clr_cnt_d  = '0;
                end else begin
                    clr_cnt_d = clr_cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                clr_cnt_d  = '0;
            end
        endcase
    end

    // Round-robin pointer advances past the winner; it survives a clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr <= '0;
        end else if (gnt_fire) begin
            rr_ptr <= (gnt_idx == PTR_W'(NR_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Storage: clear sweep or granted write. Deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            bank[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (gnt_fire && sel_we) begin
            bank[sel_addr] <= sel_wdata;
        end
    end

    // Read register with one-cycle latency and a one-hot valid pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_o <= '0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= gnt_o & {NR_REQ{!sel_we}};
            if (gnt_fire && !sel_we) begin
                rdata_o <= bank[sel_addr];
            end
        end
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Scoreboard bench for regbank_arbiter: cycle model of arbitration, bank and clear.
module tb_regbank_arbiter;

    logic        clk_i;
    logic        rstn_i;
    logic [3:0]  req_i;
    logic [3:0]  we_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic        clear_i;
    logic [3:0]  gnt_o;
    logic [3:0]  rvalid_o;
    logic [7:0]  rdata_o;
    logic        busy_o;

    typedef struct {
        int         due;
        logic [3:0] vld;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_bank [8];
    int         m_ptr;
    logic       m_busy;
    int         m_cnt;
    int         cyc;
    int         total;
    int         bad;

    regbank_arbiter dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .clear_i  (clear_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .busy_o   (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        g = '0;
        if (!m_busy && !clear_i) begin
            for (int i = 0; i < 4; i++) begin
                int j;
                j = (m_ptr + i) % 4;
                if (req_i[j] && g == 4'd0) g = 4'(1 << j);
            end
        end
        return g;
    endfunction

    task automatic set_req(input int k, input logic we, input logic [2:0] a, input logic [7:0] d);
        req_i[k]         = 1'b1;
        we_i[k]          = we;
        addr_i[k*3 +: 3] = a;
        wdata_i[k*8 +: 8] = d;
    endtask

    task automatic clr_req();
        req_i = '0;
        we_i  = '0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        logic [3:0] eg;
        exp_t       e;
        int         k;
        logic [2:0] a;
        @(negedge clk_i);
        eg = model_gnt();
        chk("gnt", 32'(gnt_o), 32'(eg));
        chk("busy", 32'(busy_o), 32'(m_busy));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rvalid", 32'(rvalid_o), 32'(e.vld));
            chk("rdata", 32'(rdata_o), 32'(e.data));
        end else begin
            chk("rvalid_idle", 32'(rvalid_o), 32'd0);
        end
        @(posedge clk_i);
        cyc++;
        if (m_busy) begin
            m_bank[m_cnt] = 8'h00;
            if (m_cnt == 7) m_busy = 1'b0;
            else m_cnt++;
        end else if (clear_i) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (eg != 4'd0) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) k = i;
            a = addr_i[k*3 +: 3];
            if (we_i[k]) begin
                m_bank[a] = wdata_i[k*8 +: 8];
            end else begin
                e.due  = cyc;
                e.vld  = eg;
                e.data = m_bank[a];
                sb.push_back(e);
            end
            m_ptr = (k + 1) % 4;
        end
        #1;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        m_ptr  = 0;
        m_busy = 1'b0;
        m_cnt  = 0;
        sb.delete();
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_gnt", 32'(gnt_o), 32'd0);
            chk("rst_rvalid", 32'(rvalid_o), 32'd0);
            chk("rst_rdata", 32'(rdata_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
        end
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        req_i   = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        clear_i = 1'b0;
        for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;

        // Reset and idle
        do_reset();
        repeat (3) cycle();

        // Write 0xA5 to addr 3 via req 0, then read it via req 1
        set_req(0, 1'b1, 3'd3, 8'hA5);
        cycle();
        clr_req();
        set_req(1, 1'b0, 3'd3, 8'h00);
        cycle();
        clr_req();
        repeat (2) cycle();

        // Fairness from reset: all four read addr 3 for 8 cycles
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 3'd3, 8'h00);
        repeat (8) cycle();
        clr_req();
        repeat (2) cycle();

        // Fill with 0xFF, clear, read every entry back
        for (int a = 0; a < 8; a++) begin
            set_req(0, 1'b1, 3'(a), 8'hFF);
            cycle();
        end
        clr_req();
        set_req(1, 1'b0, 3'd6, 8'h00);
        cycle();
        clr_req();
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        set_req(3, 1'b1, 3'd1, 8'h77);
        repeat (8) cycle();
        clr_req();
        for (int a = 0; a < 8; a++) begin
            set_req(1, 1'b0, 3'(a), 8'h00);
            cycle();
        end
        clr_req();
        repeat (2) cycle();

        // Clear racing a request, read landing just before clear, second clear ignored
        set_req(3, 1'b0, 3'd2, 8'h00);
        cycle();
        clr_req();
        clear_i = 1'b1;
        set_req(2, 1'b0, 3'd5, 8'h00);
        cycle();
        clear_i = 1'b0;
        repeat (3) cycle();
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        repeat (5) cycle();
        clr_req();
        repeat (2) cycle();

        // Reset in the middle of a clear
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i + 4), 8'(8'h30 + i));
        repeat (4) cycle();
        clr_req();
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        repeat (4) cycle();
        #2 rstn_i = 1'b0;
        #1;
        chk("midclr_busy", 32'(busy_o), 32'd0);
        chk("midclr_rvalid", 32'(rvalid_o), 32'd0);
        m_ptr  = 0;
        m_busy = 1'b0;
        m_cnt  = 0;
        sb.delete();
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), 8'(8'h50 + i));
        repeat (4) cycle();
        clr_req();
        set_req(2, 1'b0, 3'd1, 8'h00);
        cycle();
        clr_req();
        repeat (2) cycle();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
